// File: rtl/i2d_core_defines.sv
// Shared i2d core definitions: bus widths, instruction layout, opcodes and MAU types.
package i2d_core_defines;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] data_t;
    typedef logic [7:0]  opcode_t;

    localparam opcode_t OPCODE_NOP = 8'h00;
    localparam opcode_t OPCODE_LD  = 8'h10;
    localparam opcode_t OPCODE_ST  = 8'h11;

    typedef struct packed {
        opcode_t     opcode;
        logic [23:0] operand;
    } instr_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        ABORT = 2'd2,
        DONE  = 2'd3
    } mau_state_t;

    localparam logic [1:0] MAU_EXC_NONE  = 2'd0;
    localparam logic [1:0] MAU_EXC_BUS   = 2'd1;
    localparam logic [1:0] MAU_EXC_ALIGN = 2'd2;

    function automatic logic is_mem_op(input opcode_t op);
        return (op == OPCODE_LD) || (op == OPCODE_ST);
    endfunction

endpackage

// File: rtl/core_mau_if.sv
// Word-wide data bus between the MAU (master) and memory (slave); req/addr/data held until ack or err.
interface core_mau_if;
    import i2d_core_defines::*;

    logic  req;
    logic  we;
    addr_t addr;
    data_t wdata;
    logic  ack;
    logic  err;
    data_t rdata;

    modport master (output req, we, addr, wdata, input ack, err, rdata);
    modport slave  (input req, we, addr, wdata, output ack, err, rdata);
endinterface

// File: rtl/core_mau.sv
// Memory access unit: one bus transaction per LD/ST in EX, halting the pipeline until it finishes.
// Optional I2D_MAU_ALIGN_CHECK_EN raises an alignment fault instead of issuing misaligned requests.
module core_mau
    import i2d_core_defines::*;
(
    input  logic        clk,
    input  logic        rst,
    input  instr_t      ex_instr,
    input  logic        ex_flush,
    input  addr_t       mem_addr,
    input  data_t       st_data,
    core_mau_if.master  dbus,
    output data_t       mau_data,
    output logic        mau_halt,
    output logic        mau_exc,
    output logic [1:0]  mau_exc_cause,
    output addr_t       mau_exc_addr
);

    mau_state_t state, state_nxt;

    logic       mem_op;
    logic       is_st;
    logic       term;
    logic       misalign;
    addr_t      bus_addr;
    logic       unused_bits;

    logic       req_nxt, we_nxt, exc_nxt;
    addr_t      addr_nxt, exc_addr_nxt;
    data_t      wdata_nxt, data_nxt;
    logic [1:0] cause_nxt;

    assign mem_op = is_mem_op(ex_instr.opcode);
    assign is_st  = (ex_instr.opcode == OPCODE_ST);
    // err shares the terminating role of ack and takes precedence over it
    assign term   = dbus.ack | dbus.err;

`ifdef I2D_MAU_ALIGN_CHECK_EN
    assign misalign    = |mem_addr[1:0];
    assign bus_addr    = mem_addr;
    assign unused_bits = ^ex_instr.operand;
`else
    assign misalign    = 1'b0;
    assign bus_addr    = {mem_addr[31:2], 2'b00};
    assign unused_bits = ^{ex_instr.operand, mem_addr[1:0]};
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (mem_op && !ex_flush) state_nxt = misalign ? DONE : REQ;
            REQ: begin
                if (term)          state_nxt = ex_flush ? IDLE : DONE;
                else if (ex_flush) state_nxt = ABORT;
            end
            ABORT: if (term) state_nxt = IDLE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_nxt      = dbus.req;
        we_nxt       = dbus.we;
        addr_nxt     = dbus.addr;
        wdata_nxt    = dbus.wdata;
        data_nxt     = mau_data;
        exc_nxt      = mau_exc;
        cause_nxt    = mau_exc_cause;
        exc_addr_nxt = mau_exc_addr;
        case (state)
            IDLE: begin
                if (mem_op && !ex_flush) begin
                    if (misalign) begin
                        exc_nxt      = 1'b1;
                        cause_nxt    = MAU_EXC_ALIGN;
                        exc_addr_nxt = mem_addr;
                    end else begin
                        req_nxt   = 1'b1;
                        we_nxt    = is_st;
                        addr_nxt  = bus_addr;
                        wdata_nxt = st_data;
                    end
                end
            end
            REQ: begin
                if (term) begin
                    req_nxt = 1'b0;
                    // a flushed instruction still completes on the bus but leaves no trace
                    if (!ex_flush) begin
                        if (dbus.err) begin
                            exc_nxt      = 1'b1;
                            cause_nxt    = MAU_EXC_BUS;
                            exc_addr_nxt = dbus.addr;
                        end else if (!dbus.we) begin
                            data_nxt = dbus.rdata;
                        end
                    end
                end
            end
            ABORT: if (term) req_nxt = 1'b0;
            DONE: begin
                exc_nxt   = 1'b0;
                cause_nxt = MAU_EXC_NONE;
            end
            default: ;
        endcase
    end

    assign mau_halt = (mem_op && (state != DONE) && !ex_flush) || (state == ABORT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dbus.req      <= 1'b0;
            dbus.we       <= 1'b0;
            dbus.addr     <= '0;
            dbus.wdata    <= '0;
            mau_data      <= '0;
            mau_exc       <= 1'b0;
            mau_exc_cause <= MAU_EXC_NONE;
            mau_exc_addr  <= '0;
        end else begin
            dbus.req      <= req_nxt;
            dbus.we       <= we_nxt;
            dbus.addr     <= addr_nxt;
            dbus.wdata    <= wdata_nxt;
            mau_data      <= data_nxt;
            mau_exc       <= exc_nxt;
            mau_exc_cause <= cause_nxt;
            mau_exc_addr  <= exc_addr_nxt;
        end
    end

endmodule
